// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame receiver.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StPar,
        StStop
    } state_e;

    localparam int unsigned DefaultWidth = 4;

    // Counter must hold 0..width inclusive.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sfr_shift.sv
// WIDTH-bit shift register, enable-gated, loads serial input into bit 0.
module sfr_shift #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] shift_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            shift_q <= '0;
        end else if (en) begin
            shift_q <= {shift_q[WIDTH-2:0], din};
        end
    end

    assign q = shift_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, WIDTH data bits MSB first, optional even parity, stop bit.
// Define SERIAL_FRAME_RX_PARITY_EN to expect a parity bit between data and stop.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             CE,
    input  logic             SI,
    output logic [WIDTH-1:0] O,
    output logic             VALID,
    output logic             FERR,
    output logic             PERR,
    output logic             BUSY
);

    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic [WIDTH-1:0] shreg;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             shift_en;
    logic             par_bad;

    sfr_shift #(
        .WIDTH(WIDTH)
    ) u_shift (
        .clk (CLK),
        .rstn(RESETN),
        .en  (shift_en),
        .din (SI),
        .q   (shreg)
    );

`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic par_err_q, par_err_d;
    logic perr_q, perr_d;

    always_comb begin
        par_err_d = par_err_q;
        perr_d    = 1'b0;
        if (CE && state_q == StPar) begin
            // Even parity: data plus parity bit must XOR to zero.
            par_err_d = (^shreg) ^ SI;
        end
        if (CE && state_q == StStop) begin
            perr_d = par_err_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            par_err_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
            perr_q    <= perr_d;
        end
    end

    assign par_bad = par_err_q;
    assign PERR    = perr_q;
`else
    assign par_bad = 1'b0;
    assign PERR    = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        o_d      = o_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        shift_en = 1'b0;
        if (CE) begin
            unique case (state_q)
                StIdle: begin
                    if (!SI) begin
                        state_d = StData;
                        cnt_d   = '0;
                    end
                end
                StData: begin
                    shift_en = 1'b1;
                    cnt_d    = cnt_q + CntW'(1);
                    if (cnt_q == LastBit) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        state_d = StPar;
`else
                        state_d = StStop;
`endif
                    end
                end
`ifdef SERIAL_FRAME_RX_PARITY_EN
                StPar: begin
                    state_d = StStop;
                end
`endif
                StStop: begin
                    state_d = StIdle;
                    ferr_d  = !SI;
                    if (SI && !par_bad) begin
                        valid_d = 1'b1;
                        o_d     = shreg;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            o_q     <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign O     = o_q;
    assign VALID = valid_q;
    assign FERR  = ferr_q;
    assign BUSY  = (state_q != StIdle);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx; follows SERIAL_FRAME_RX_PARITY_EN like the RTL.
module tb_serial_frame_rx;

    localparam int unsigned W = 4;

    logic         clk  = 1'b0;
    logic         rstn = 1'b0;
    logic         ce   = 1'b0;
    logic         si   = 1'b1;
    logic [W-1:0] o;
    logic         valid, ferr, perr, busy;

    serial_frame_rx #(
        .WIDTH(W)
    ) dut (
        .CLK   (clk),
        .RESETN(rstn),
        .CE    (ce),
        .SI    (si),
        .O     (o),
        .VALID (valid),
        .FERR  (ferr),
        .PERR  (perr),
        .BUSY  (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]   flags;  // {valid, ferr, perr}
        logic [W-1:0] data;   // O expected while the pulse is high
    } exp_t;

    exp_t         exp_q[$];
    int           total    = 0;
    int           bad      = 0;
    int           cyc      = 0;
    int           stop_cyc = -1;
    logic [W-1:0] o_model  = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (valid || ferr || perr) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {29'd0, valid, ferr, perr}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("flags", {29'd0, valid, ferr, perr}, {29'd0, e.flags});
                check("o_at_pulse", {28'd0, o}, {28'd0, e.data});
                check("latency", cyc, stop_cyc);
            end
        end
    end

    // Called on a negedge; one CE pulse every 4 CLK, sampled at the 4th posedge.
    task automatic send_bit(input logic b, input bit is_stop);
        si = b;
        ce = 1'b0;
        repeat (3) @(negedge clk);
        ce = 1'b1;
        if (is_stop) stop_cyc = cyc + 1;
        @(negedge clk);
        ce = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic stop, input logic flip,
                              input int gap_at);
        exp_t         e;
        logic         pe;
        logic [W-1:0] o_before;
        int           n;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        pe = flip;
`else
        pe = 1'b0;
`endif
        e.flags = {stop & ~pe, ~stop, pe};
        if (e.flags[2]) o_model = d;
        e.data = o_model;
        exp_q.push_back(e);
        send_bit(1'b0, 1'b0);
        n = 0;
        for (int i = W - 1; i >= 0; i--) begin
            send_bit(d[i], 1'b0);
            n++;
            if (n == gap_at) begin
                o_before = o;
                repeat (50) @(negedge clk);
                check("busy_in_gap", {31'd0, busy}, 32'd1);
                check("o_in_gap", {28'd0, o}, {28'd0, o_before});
            end
        end
`ifdef SERIAL_FRAME_RX_PARITY_EN
        send_bit((^d) ^ flip, 1'b0);
`endif
        send_bit(stop, 1'b1);
    endtask

    initial begin
        logic [W-1:0] rd;
        logic         rs, rf;
        repeat (3) @(negedge clk);
        check("rst_o", {28'd0, o}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_ferr", {31'd0, ferr}, 32'd0);
        check("rst_perr", {31'd0, perr}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        send_frame(4'hB, 1'b1, 1'b0, -1);
        repeat (3) @(negedge clk);
        check("busy_after_B", {31'd0, busy}, 32'd0);
        check("o_after_B", {28'd0, o}, 32'hB);

        send_frame(4'h6, 1'b0, 1'b0, -1);
        repeat (3) @(negedge clk);
        check("o_after_ferr", {28'd0, o}, 32'hB);

`ifdef SERIAL_FRAME_RX_PARITY_EN
        send_frame(4'hB, 1'b1, 1'b0, -1);
        send_frame(4'hB, 1'b1, 1'b1, -1);
        send_frame(4'h3, 1'b0, 1'b1, -1);
        repeat (3) @(negedge clk);
`endif

        // Abort a frame after the 2nd data bit.
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        check("busy_mid_frame", {31'd0, busy}, 32'd1);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        o_model = '0;
        check("o_after_abort", {28'd0, o}, 32'd0);
        check("busy_after_abort", {31'd0, busy}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        send_frame(4'h6, 1'b1, 1'b0, -1);
        repeat (3) @(negedge clk);
        check("o_after_6", {28'd0, o}, 32'h6);

        send_frame(4'hB, 1'b1, 1'b0, 2);
        repeat (3) @(negedge clk);
        check("o_after_gap", {28'd0, o}, 32'hB);

        send_frame(4'hA, 1'b1, 1'b0, -1);
        send_frame(4'h5, 1'b1, 1'b0, -1);
        repeat (3) @(negedge clk);
        check("o_after_b2b", {28'd0, o}, 32'h5);

        for (int k = 0; k < 6; k++) begin
            rd = W'($urandom_range(0, 15));
            rs = 1'($urandom_range(0, 3) != 0);
            rf = 1'($urandom_range(0, 1));
            send_frame(rd, rs, rf, -1);
        end

        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        check("final_busy", {31'd0, busy}, 32'd0);
        check("final_o", {28'd0, o}, {28'd0, o_model});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
